// File: rtl/rps_pkg.sv
// Shared encodings for the rock/paper/scissor computer-player engines:
// move codes, the state enum of the prediction FSM and the beat() helper.
package rps_pkg;

    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;
    localparam logic [1:0] NONE    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SCAN0,
        SCAN1,
        SCAN2,
        DONE
    } state_t;

    // Returns the move that defeats the given move; NONE has no answer.
    function automatic logic [1:0] beat(input logic [1:0] mv);
        case (mv)
            ROCK:    beat = PAPER;
            SCISSOR: beat = ROCK;
            PAPER:   beat = SCISSOR;
            default: beat = NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_sync.sv
// Synchroniser for an active-low push button plus a one-cycle pulse on
// each press (1->0 transition of the synchronised level). The chain resets
// to the released level so leaving reset never looks like a press.
module button_sync #(
    parameter int STAGES = 2
)(
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;

    // Shift the raw button into the clock domain and remember the last level.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= (sync_q << 1) | STAGES'(btn);
            level_q <= sync_q[STAGES-1];
        end
    end

    assign fall = level_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/markov_predictor.sv
// Computer player that learns the user's move-to-move habits. A 3x3 table
// of saturating transition counts (previous move -> next move) is updated on
// every valid round press; the most frequent successor of the current move
// becomes the prediction and the engine answers with the move that beats it.
module markov_predictor
    import rps_pkg::*;
#(
    parameter int         CNT_W          = 8,
    parameter int         SYNC_STAGES    = 2,
    parameter logic [1:0] DEFAULT_CHOICE = 2'b10
)(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] user,
    output logic [1:0] choice,
    output logic       ready,
    output logic [1:0] predicted
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             press;
    logic [1:0]       user_sync_q [SYNC_STAGES];
    logic [1:0]       user_sync;
    logic             accept;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count [3][3];
    logic             prev_valid;
    logic [1:0]       prev_move;
    logic [1:0]       u_cap;
    logic [1:0]       best_idx;
    logic [CNT_W-1:0] best_val;

    button_sync #(
        .STAGES (SYNC_STAGES)
    ) u_start_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .btn      (start),
        .fall     (press)
    );

    // Plain synchroniser for the user switches, same depth as the button so
    // the captured move lines up with the press pulse.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) user_sync_q[i] <= NONE;
        end else begin
            user_sync_q[0] <= user;
            for (int i = 1; i < SYNC_STAGES; i++) user_sync_q[i] <= user_sync_q[i-1];
        end
    end

    assign user_sync = user_sync_q[SYNC_STAGES-1];
    assign accept    = press && (state == IDLE) && (user_sync != NONE);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: one cycle per step once a valid press is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = UPDATE;
            UPDATE:  state_next = SCAN0;
            SCAN0:   state_next = SCAN1;
            SCAN1:   state_next = SCAN2;
            SCAN2:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table update, row scan and output registers driven by the current state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    count[i][j] <= '0;
            prev_valid <= 1'b0;
            prev_move  <= ROCK;
            u_cap      <= ROCK;
            best_idx   <= ROCK;
            best_val   <= '0;
            choice     <= DEFAULT_CHOICE;
            ready      <= 1'b1;
            predicted  <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        u_cap <= user_sync;
                        ready <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (prev_valid) begin
                        if (count[prev_move][u_cap] == CNT_MAX) begin
                            for (int j = 0; j < 3; j++)
                                count[prev_move][j] <= count[prev_move][j] >> 1;
                            count[prev_move][u_cap] <= (CNT_MAX >> 1) + 1'b1;
                        end else begin
                            count[prev_move][u_cap] <= count[prev_move][u_cap] + 1'b1;
                        end
                    end
                    prev_move  <= u_cap;
                    prev_valid <= 1'b1;
                end
                SCAN0: begin
                    best_idx <= ROCK;
                    best_val <= count[u_cap][0];
                end
                SCAN1: begin
                    if (count[u_cap][1] > best_val) begin
                        best_idx <= SCISSOR;
                        best_val <= count[u_cap][1];
                    end
                end
                SCAN2: begin
                    if (count[u_cap][2] > best_val) begin
                        best_idx <= PAPER;
                        best_val <= count[u_cap][2];
                    end
                end
                DONE: begin
                    if (best_val == '0) begin
                        predicted <= NONE;
                        choice    <= DEFAULT_CHOICE;
                    end else begin
                        predicted <= best_idx;
                        choice    <= beat(best_idx);
                    end
                    ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
